// File: rtl/evo_pkg.sv
// Shared types and width helpers for the evolvable gate array.
package evo_pkg;

   typedef enum logic [2:0] {
      FnAnd  = 3'd0,
      FnOr   = 3'd1,
      FnNand = 3'd2,
      FnNor  = 3'd3,
      FnXor  = 3'd4,
      FnXnor = 3'd5,
      FnNotA = 3'd6,
      FnBufA = 3'd7
   } func_e;

   typedef enum logic [2:0] {
      StIdle,
      StLoad,
      StSettle,
      StCheck,
      StDone
   } state_e;

   function automatic int unsigned sel_w(int unsigned num_in, int unsigned num_gates);
      return $clog2(num_in + num_gates);
   endfunction

   function automatic int unsigned gene_w(int unsigned num_in, int unsigned num_gates);
      return 3 + 2 * sel_w(num_in, num_gates);
   endfunction

endpackage

// File: rtl/evo_cell.sv
// One reconfigurable 2-input cell: two source muxes, a function LUT and a state flop.
module evo_cell import evo_pkg::*; #(
   parameter int unsigned NUM_IN    = 4,
   parameter int unsigned NUM_GATES = 8,
   localparam int unsigned SEL_W    = sel_w(NUM_IN, NUM_GATES),
   localparam int unsigned GENE_W   = gene_w(NUM_IN, NUM_GATES),
   localparam int unsigned NSRC     = NUM_IN + NUM_GATES
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              clr,
   input  logic [GENE_W-1:0] gene,
   input  logic [NSRC-1:0]   srcs,
   output logic              gate
);

   logic [2**SEL_W-1:0] src_ext;
   logic [SEL_W-1:0]    sel_a, sel_b;
   func_e               func;
   logic                a, b, nxt, gate_q;

   assign func  = func_e'(gene[GENE_W-1 -: 3]);
   assign sel_a = gene[2*SEL_W-1 -: SEL_W];
   assign sel_b = gene[SEL_W-1:0];

   // Selects beyond the last gate land in the zero padding.
   always_comb begin
      src_ext = '0;
      src_ext[NSRC-1:0] = srcs;
   end

   assign a = src_ext[sel_a];
   assign b = src_ext[sel_b];

   always_comb begin
      nxt = 1'b0;
      unique case (func)
         FnAnd:  nxt = a & b;
         FnOr:   nxt = a | b;
         FnNand: nxt = ~(a & b);
         FnNor:  nxt = ~(a | b);
         FnXor:  nxt = a ^ b;
         FnXnor: nxt = ~(a ^ b);
         FnNotA: nxt = ~a;
         FnBufA: nxt = a;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gate_q <= 1'b0;
      end else if (clr) begin
         gate_q <= 1'b0;
      end else if (en) begin
         gate_q <= nxt;
      end
   end

   assign gate = gate_q;

endmodule

// File: rtl/evo_gate_array.sv
// Run-time reconfigurable gate network with genome loader and settle/stability controller.
module evo_gate_array import evo_pkg::*; #(
   parameter int unsigned NUM_IN        = 4,
   parameter int unsigned NUM_GATES     = 8,
   parameter int unsigned NUM_OUT       = 1,
   parameter int unsigned SETTLE_CYCLES = 16,
   parameter int unsigned STABLE_CYCLES = 8,
   localparam int unsigned SEL_W        = sel_w(NUM_IN, NUM_GATES),
   localparam int unsigned GENE_W       = gene_w(NUM_IN, NUM_GATES)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cfg_valid,
   output logic               cfg_ready,
   input  logic [GENE_W-1:0]  cfg_data,
   output logic               cfg_done,
   input  logic               eval_start,
   input  logic [NUM_IN-1:0]  eval_vec,
   output logic               result_valid,
   input  logic               result_ready,
   output logic [NUM_OUT-1:0] result_out,
   output logic               result_unstable,
   output logic               busy
);

   localparam int unsigned PTR_W   = (NUM_GATES > 1) ? $clog2(NUM_GATES) : 1;
   localparam int unsigned MAX_CNT = (SETTLE_CYCLES > STABLE_CYCLES) ? SETTLE_CYCLES
                                                                     : STABLE_CYCLES;
   localparam int unsigned CNT_W   = $clog2(MAX_CNT + 1);
   localparam int unsigned TAP     = NUM_GATES - NUM_OUT;

   state_e               state_q, state_d;
   logic [PTR_W-1:0]     ptr_q, ptr_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [NUM_IN-1:0]    vec_q, vec_d;
   logic [NUM_OUT-1:0]   snap_q, snap_d;
   logic                 unstable_q, unstable_d;
   logic                 done_q, done_d;
   logic [GENE_W-1:0]    gene_q [NUM_GATES];
   logic [NUM_GATES-1:0] gates;
   logic [NUM_OUT-1:0]   tap;
   logic                 gene_we, cell_clr, cell_en;

   assign tap             = gates[TAP +: NUM_OUT];
   assign cell_en         = (state_q == StSettle) || (state_q == StCheck);
   assign cfg_ready       = (state_q == StIdle) || (state_q == StLoad);
   assign busy            = (state_q != StIdle);
   assign result_valid    = (state_q == StDone);
   assign result_out      = snap_q;
   assign result_unstable = unstable_q;
   assign cfg_done        = done_q;

   for (genvar g = 0; g < NUM_GATES; g++) begin : g_cell
      evo_cell #(
         .NUM_IN    (NUM_IN),
         .NUM_GATES (NUM_GATES)
      ) u_cell (
         .clk  (clk),
         .rst  (rst),
         .en   (cell_en),
         .clr  (cell_clr),
         .gene (gene_q[g]),
         .srcs ({gates, vec_q}),
         .gate (gates[g])
      );
   end

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      cnt_d      = cnt_q;
      vec_d      = vec_q;
      snap_d     = snap_q;
      unstable_d = unstable_q;
      done_d     = 1'b0;
      gene_we    = 1'b0;
      cell_clr   = 1'b0;
      unique case (state_q)
         StIdle, StLoad: begin
            if (cfg_valid) begin
               gene_we = 1'b1;
               if (ptr_q == PTR_W'(NUM_GATES - 1)) begin
                  ptr_d   = '0;
                  done_d  = 1'b1;
                  state_d = StIdle;
               end else begin
                  ptr_d   = ptr_q + 1'b1;
                  state_d = StLoad;
               end
            end else if ((state_q == StIdle) && eval_start) begin
               vec_d    = eval_vec;
               cell_clr = 1'b1;
               cnt_d    = CNT_W'(SETTLE_CYCLES);
               state_d  = StSettle;
            end
         end
         StSettle: begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) begin
               cnt_d      = CNT_W'(STABLE_CYCLES);
               unstable_d = 1'b0;
               state_d    = StCheck;
            end
         end
         StCheck: begin
            cnt_d = cnt_q - 1'b1;
            // First CHECK cycle shows the gates as left by the final SETTLE edge: that is the
            // snapshot, and it trivially matches itself.
            if (cnt_q == CNT_W'(STABLE_CYCLES)) begin
               snap_d = tap;
            end else if (tap != snap_q) begin
               unstable_d = 1'b1;
            end
            if (cnt_q == CNT_W'(1)) begin
               state_d = StDone;
            end
         end
         StDone: begin
            if (result_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StIdle;
         ptr_q      <= '0;
         cnt_q      <= '0;
         vec_q      <= '0;
         snap_q     <= '0;
         unstable_q <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         cnt_q      <= cnt_d;
         vec_q      <= vec_d;
         snap_q     <= snap_d;
         unstable_q <= unstable_d;
         done_q     <= done_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_GATES; i++) begin
            gene_q[i] <= '0;
         end
      end else if (gene_we) begin
         gene_q[ptr_q] <= cfg_data;
      end
   end

endmodule
